// File: rtl/if_id_queue.sv
// DEPTH-entry instruction queue between fetch and decode, replacing the single IF/ID latch.
// Valid/ready on both sides, branch-kill flush, zero bubble when empty, occupancy count.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    // Handshake flags depend only on registered occupancy, so no id_ready -> if_ready path.
    assign if_ready = (count_q != CNT_W'(DEPTH));
    assign id_valid = (count_q != '0);
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_ready;
    assign count    = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (kill) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage carries no reset; a killed push must not disturb it.
    always_ff @(posedge clk) begin
        if (push && !kill) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
        end
    end

    assign id_pc   = id_valid ? pc_mem[rd_ptr]   : '0;
    assign id_inst = id_valid ? inst_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue (DEPTH=4): a queue model tracks accepted entries
// and every cycle the observed handshake/count/head is compared against it.
module tb_if_id_queue;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SNAP_W = 2 + CNT_W + ADDR_W + INST_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic              clk;
    logic              rst;
    logic              kill;
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_ready;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;

    entry_t sb[$];
    int     checks   = 0;
    int     failures = 0;

    if_id_queue #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .kill    (kill),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc   (if_pc),
        .if_inst (if_inst),
        .id_ready(id_ready),
        .id_valid(id_valid),
        .id_pc   (id_pc),
        .id_inst (id_inst),
        .count   (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hA5A5_3C3C;
    endfunction

    function automatic logic [SNAP_W-1:0] model_snap();
        if (sb.size() == 0)
            return {1'b1, 1'b0, CNT_W'(0), {ADDR_W{1'b0}}, {INST_W{1'b0}}};
        return {sb.size() != DEPTH, 1'b1, CNT_W'(sb.size()), sb[0].pc, sb[0].inst};
    endfunction

    function automatic logic [SNAP_W-1:0] dut_snap();
        return {if_ready, id_valid, count, id_pc, id_inst};
    endfunction

    // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
    task automatic step(input logic v, input logic [ADDR_W-1:0] pc, input logic rdy, input logic k);
        logic   do_push;
        logic   do_pop;
        entry_t e;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
        id_ready = rdy;
        kill     = k;
        do_push  = v && (sb.size() < DEPTH);
        do_pop   = (sb.size() != 0) && rdy;
        e.pc     = pc;
        e.inst   = inst_of(pc);
        @(posedge clk);
        if (k) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(e);
        end
        @(negedge clk);
        if_valid = 1'b0;
        id_ready = 1'b0;
        kill     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_snap() !== {1'b1, 1'b0, CNT_W'(0), {ADDR_W{1'b0}}, {INST_W{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL reset_state obs=%h exp=%h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            checks++;
            if (dut_snap() !== model_snap()) begin
                failures++;
                $display("[TB] FAIL fill_snap[%0d] obs=%h exp=%h", i, dut_snap(), model_snap());
            end
            checks++;
            if (count !== CNT_W'(i + 1) || id_pc !== 32'h100) begin
                failures++;
                $display("[TB] FAIL fill_count_head[%0d] count=%0d pc=%h exp count=%0d pc=100", i, count, id_pc, i + 1);
            end
        end
        checks++;
        if (if_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_full_ready obs=%b exp=0", if_ready);
        end
    endtask

    task automatic test_full_push_pop();
        step(1'b1, 32'h110, 1'b1, 1'b0);
        checks++;
        if (count !== CNT_W'(3) || id_pc !== 32'h104 || dut_snap() !== model_snap()) begin
            failures++;
            $display("[TB] FAIL full_pushpop obs=%h exp=%h", dut_snap(), model_snap());
        end
        step(1'b1, 32'h110, 1'b0, 1'b0);
        checks++;
        if (count !== CNT_W'(4) || if_ready !== 1'b0 || dut_snap() !== model_snap()) begin
            failures++;
            $display("[TB] FAIL full_refill obs=%h exp=%h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h400 + 32'(8 * i), 1'b1, 1'b0);
            checks++;
            if (id_pc !== 32'h400 + 32'(8 * i) || count !== CNT_W'(1) || id_inst !== inst_of(32'h400 + 32'(8 * i))) begin
                failures++;
                $display("[TB] FAIL stream[%0d] pc=%h count=%0d exp pc=%h count=1", i, id_pc, count, 32'h400 + 32'(8 * i));
            end
        end
    endtask

    task automatic test_kill();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
        checks++;
        if (dut_snap() !== model_snap()) begin
            failures++;
            $display("[TB] FAIL kill_prefill obs=%h exp=%h", dut_snap(), model_snap());
        end
        step(1'b1, 32'h50C, 1'b1, 1'b1);
        checks++;
        if (dut_snap() !== {1'b1, 1'b0, CNT_W'(0), {ADDR_W{1'b0}}, {INST_W{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL kill_flush obs=%h exp=%h", dut_snap(), model_snap());
        end
        step(1'b1, 32'h200, 1'b0, 1'b0);
        checks++;
        if (id_pc !== 32'h200 || count !== CNT_W'(1) || dut_snap() !== model_snap()) begin
            failures++;
            $display("[TB] FAIL kill_next_push obs=%h exp=%h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] seen[$];
        int pushed;
        int cyc;
        logic rdy;
        do_reset();
        pushed = 0;
        cyc    = 0;
        while (seen.size() < 10 && cyc < 60) begin
            rdy = (cyc % 3) != 2;
            if (rdy && sb.size() != 0) seen.push_back(id_pc);
            step(pushed < 10, 32'h300 + 32'(4 * pushed), rdy, 1'b0);
            if (pushed < 10 && sb.size() != 0 && sb[sb.size() - 1].pc == 32'h300 + 32'(4 * pushed)) pushed++;
            checks++;
            if (dut_snap() !== model_snap()) begin
                failures++;
                $display("[TB] FAIL wrap_snap[%0d] obs=%h exp=%h", cyc, dut_snap(), model_snap());
            end
            cyc++;
        end
        checks++;
        if (seen.size() != 10) begin
            failures++;
            $display("[TB] FAIL wrap_timeout popped=%0d exp=10", seen.size());
        end
        for (int k = 0; k < seen.size(); k++) begin
            checks++;
            if (seen[k] !== 32'h300 + 32'(4 * k)) begin
                failures++;
                $display("[TB] FAIL wrap_order[%0d] obs=%h exp=%h", k, seen[k], 32'h300 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 32'h600, 1'b0, 1'b0);
        step(1'b1, 32'h604, 1'b0, 1'b0);
        checks++;
        if (count !== CNT_W'(2)) begin
            failures++;
            $display("[TB] FAIL areset_pre count=%0d exp=2", count);
        end
        #2 rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (dut_snap() !== {1'b1, 1'b0, CNT_W'(0), {ADDR_W{1'b0}}, {INST_W{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL areset_mid obs=%h exp=%h", dut_snap(), model_snap());
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h700, 1'b0, 1'b0);
        checks++;
        if (id_pc !== 32'h700 || dut_snap() !== model_snap()) begin
            failures++;
            $display("[TB] FAIL areset_recover obs=%h exp=%h", dut_snap(), model_snap());
        end
    endtask

    initial begin
        rst      = 1'b1;
        kill     = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_full_push_pop();
        test_streaming();
        test_kill();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised successor to the single-entry IF/ID pipeline latch. It is a DEPTH-entry instruction queue between fetch and decode, with valid/ready handshakes on both sides, a branch-kill flush, bubble (all-zero) output when empty, and an occupancy count. Fetch can run ahead of decode stalls by up to DEPTH instructions, so decode no longer stalls fetch directly.

## Interface
- ADDR_W, default 32: PC width.
- INST_W, default 32: instruction width.
- DEPTH, default 4: number of entries. Must be a power of 2 and at least 2.
- CNT_W, default $clog2(DEPTH+1): width of `count`. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- kill  in  1  branch taken in ID; flushes the queue.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  queue can accept an entry this cycle.
- if_pc  in  ADDR_W  PC of the fetched instruction.
- if_inst  in  INST_W  fetched instruction.
- id_ready  in  1  decode consumes the head entry this cycle (low = ID stall).
- id_valid  out  1  head entry is valid.
- id_pc  out  ADDR_W  PC of the head entry; 0 when empty.
- id_inst  out  INST_W  instruction of the head entry; 0 when empty.
- count  out  CNT_W  number of occupied entries, 0..DEPTH.

## Operation
- State: storage array of DEPTH × (ADDR_W+INST_W), rd_ptr and wr_ptr of $clog2(DEPTH) bits each (natural wrap), and a count register.
- push = if_valid & if_ready. pop = id_valid & id_ready.
- if_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from id_ready. A full queue refuses a push even in a cycle that pops.
- id_valid = (count != 0). id_pc and id_inst come from storage[rd_ptr] when id_valid=1. When empty they are forced to 0, so ID sees the same zero-instruction bubble as the old latch.
- Normal edge, kill=0:
  - push writes storage[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
  - count becomes count + push − pop. Push and pop in the same cycle leave count unchanged.
- Kill edge, kill=1: kill takes priority over everything.
  - rd_ptr, wr_ptr and count go to 0.
  - A push in the same cycle is discarded and storage is not written.
  - A pop in the same cycle has no further effect.
  - if_ready and id_valid are not gated by kill. Upstream sees its handshake complete, and the flushed instruction is dropped by design.
- Reset (asserted at any time, including mid-operation): rd_ptr, wr_ptr and count go to 0 immediately and asynchronously. Storage is not reset.
- Width rule: count never exceeds DEPTH and never underflows. Push while full and pop while empty cannot occur by construction.

## Timing
- Reset values: if_ready=1, id_valid=0, id_pc=0, id_inst=0, count=0.
- Latency: an entry pushed at edge N is visible on id_* after edge N, i.e. in cycle N+1. There is no same-cycle fall-through. An empty queue with continuous push and pop gives 1 entry/cycle throughput at 1-cycle latency.
- After a kill edge, id_valid=0 and id_* are 0 in the next cycle. The first post-kill instruction can be pushed in that same cycle.
- count, if_ready and id_valid all change only on clk edges or on rst assertion.
- id_pc and id_inst are a mux of registers. A decode stall (id_ready=0) holds the head entry stable indefinitely.

## Test plan
- Reset, then fill: DEPTH=4, push PCs 0x100, 0x104, 0x108, 0x10C with id_ready=0.
  - Required: count steps 1→4, if_ready=0 at count=4, and id_pc holds 0x100 throughout.
- Streaming: push and pop every cycle from empty.
  - Required: id_pc in cycle N+1 equals if_pc from cycle N, and count stays at 1.
- Full, simultaneous push and pop: with count=4, assert if_valid=1 and id_ready=1.
  - Required: only the pop happens, count=3, then the next push is accepted and count returns to 4.
- Kill mid-stream: with count=3 plus an active push and pop, assert kill for one cycle.
  - Required: next cycle count=0, id_valid=0, id_pc=0, id_inst=0. A push of 0x200 in the following cycle appears on id_pc one cycle later.
- Wrap-around: perform 10 push/pop pairs with a pop delayed every third cycle.
  - Required: output PC order exactly matches input order across pointer wrap.
- Asynchronous reset mid-operation: assert rst between clock edges while count=2.
  - Required: before the next edge, count=0, id_valid=0, id_* = 0 and if_ready=1.
